// File: rtl/vga_fifo_pl_pkg.sv
// vga_fifo_pl_pkg: shared types for the pixel-path FIFO
package vga_fifo_pl_pkg;
  typedef struct packed {
    logic ovf;
    logic udf;
  } err_t;
endpackage

// File: rtl/vga_fifo_pl_if.sv
// vga_fifo_pl_if: write/read/status bundle between wishbone master, FIFO and pixel generator
interface vga_fifo_pl_if #(parameter int AWIDTH = 7, parameter int DWIDTH = 32);
  logic [DWIDTH-1:0] d;
  logic wreq;
  logic rreq;
  logic [DWIDTH-1:0] q;
  logic [AWIDTH:0] afull_lvl;
  logic [AWIDTH:0] aempty_lvl;
  logic [AWIDTH:0] level;
  logic empty;
  logic hfull;
  logic full;
  logic afull;
  logic aempty;
  logic ovf;
  logic udf;
  modport master (
    output d, wreq, rreq, afull_lvl, aempty_lvl,
    input q, level, empty, hfull, full, afull, aempty, ovf, udf
  );
  modport slave (
    input d, wreq, rreq, afull_lvl, aempty_lvl,
    output q, level, empty, hfull, full, afull, aempty, ovf, udf
  );
endinterface

// File: rtl/vga_fifo_dpram.sv
// vga_fifo_dpram: write-synchronous, read-asynchronous dual-port memory
module vga_fifo_dpram #(parameter int AWIDTH = 7, parameter int DWIDTH = 32) (
  input  logic              clk,
  input  logic              we,
  input  logic [AWIDTH-1:0] waddr,
  input  logic [DWIDTH-1:0] wdata,
  input  logic [AWIDTH-1:0] raddr,
  output logic [DWIDTH-1:0] rdata
);
  logic [DWIDTH-1:0] mem [2**AWIDTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/vga_fifo_pl.sv
// vga_fifo_pl: show-ahead FIFO with fill level, programmable thresholds and sticky errors
module vga_fifo_pl
  import vga_fifo_pl_pkg::*;
#(parameter int AWIDTH = 7, parameter int DWIDTH = 32) (
  input logic clk,
  input logic aclr,
  input logic sclr,
  vga_fifo_pl_if.slave bus
);
  localparam int DEPTH = 2**AWIDTH;
  logic [AWIDTH-1:0] rptr, wptr;
  logic [AWIDTH:0] level;
  err_t err;
  logic empty, full, rd_acc, wr_acc;
  always_comb begin
    empty  = level == '0;
    full   = level == (AWIDTH+1)'(DEPTH);
    rd_acc = bus.rreq & ~empty;
    wr_acc = bus.wreq & (~full | bus.rreq);
  end
  always_ff @(posedge clk or negedge aclr)
    if (!aclr) begin
      rptr  <= '0;
      wptr  <= '0;
      level <= '0;
      err   <= '0;
    end else if (sclr) begin
      rptr  <= '0;
      wptr  <= '0;
      level <= '0;
      err   <= '0;
    end else begin
      rptr    <= rptr + AWIDTH'(rd_acc);
      wptr    <= wptr + AWIDTH'(wr_acc);
      level   <= level + (AWIDTH+1)'(wr_acc) - (AWIDTH+1)'(rd_acc);
      err.ovf <= err.ovf | (bus.wreq & ~wr_acc);
      err.udf <= err.udf | (bus.rreq & ~rd_acc);
    end
  // sclr also blocks the memory write so an ignored request leaves mem untouched
  vga_fifo_dpram #(.AWIDTH(AWIDTH), .DWIDTH(DWIDTH)) u_mem (
    .clk  (clk),
    .we   (wr_acc & ~sclr),
    .waddr(wptr),
    .wdata(bus.d),
    .raddr(rptr),
    .rdata(bus.q)
  );
  assign bus.level  = level;
  assign bus.empty  = empty;
  assign bus.full   = full;
  assign bus.hfull  = level >= (AWIDTH+1)'(DEPTH/2);
  assign bus.afull  = level >= bus.afull_lvl;
  assign bus.aempty = level <= bus.aempty_lvl;
  assign bus.ovf    = err.ovf;
  assign bus.udf    = err.udf;
endmodule

// File: tb/tb_vga_fifo_pl.sv
// tb_vga_fifo_pl: table vectors, directed corner cases and randomized run against a queue model
module tb_vga_fifo_pl;
  localparam int AW = 3;
  localparam int DW = 8;
  localparam int DEPTH = 8;
  logic clk = 0, aclr = 0, sclr = 0;
  vga_fifo_pl_if #(.AWIDTH(AW), .DWIDTH(DW)) bus();
  vga_fifo_pl #(.AWIDTH(AW), .DWIDTH(DW)) dut (.clk(clk), .aclr(aclr), .sclr(sclr), .bus(bus));
  always #5 clk = ~clk;
  int checks = 0, failures = 0;
  logic [7:0] mq[$];
  bit m_ovf = 0, m_udf = 0;
  typedef struct {
    bit w, r;
    logic [7:0] d;
    int lvl;
    logic [7:0] q;
    bit emp, hf, fl, ov, ud;
  } vec_t;
  vec_t tv[18];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_ovf = 0;
    m_udf = 0;
  endtask

  task automatic drive(bit w, bit r, logic [7:0] dv, bit s);
    bit e, f, rd, wr;
    bus.wreq = w;
    bus.rreq = r;
    bus.d = dv;
    sclr = s;
    @(posedge clk);
    if (s) model_clear();
    else begin
      e = mq.size() == 0;
      f = mq.size() == DEPTH;
      rd = r && !e;
      wr = w && (!f || r);
      if (w && !wr) m_ovf = 1;
      if (r && !rd) m_udf = 1;
      if (rd) void'(mq.pop_front());
      if (wr) mq.push_back(dv);
    end
    #1;
    bus.wreq = 0;
    bus.rreq = 0;
    sclr = 0;
  endtask

  task automatic check_model(string tag);
    int n;
    n = mq.size();
    chk({tag, ".level"}, 32'(bus.level), n);
    chk({tag, ".empty"}, 32'(bus.empty), 32'(n == 0));
    chk({tag, ".full"}, 32'(bus.full), 32'(n == DEPTH));
    chk({tag, ".hfull"}, 32'(bus.hfull), 32'(n >= DEPTH / 2));
    chk({tag, ".afull"}, 32'(bus.afull), 32'(n >= int'(bus.afull_lvl)));
    chk({tag, ".aempty"}, 32'(bus.aempty), 32'(n <= int'(bus.aempty_lvl)));
    chk({tag, ".ovf"}, 32'(bus.ovf), 32'(m_ovf));
    chk({tag, ".udf"}, 32'(bus.udf), 32'(m_udf));
    if (n > 0) chk({tag, ".q"}, 32'(bus.q), 32'(mq[0]));
  endtask

  initial begin
    int wp;
    bus.wreq = 0;
    bus.rreq = 0;
    bus.d = 0;
    bus.afull_lvl = 8;
    bus.aempty_lvl = 0;
    for (int i = 0; i < 8; i++)
      tv[i] = '{1, 0, 8'((i + 1) * 17), i + 1, 8'h11, 0, (i + 1) >= 4, (i + 1) == 8, 0, 0};
    tv[8] = '{1, 0, 8'hEE, 8, 8'h11, 0, 1, 1, 1, 0};
    for (int k = 0; k < 8; k++)
      tv[9 + k] = '{0, 1, 8'h00, 7 - k, 8'((k + 2) * 17), k == 7, (7 - k) >= 4, 0, 1, 0};
    tv[17] = '{0, 1, 8'h00, 0, 8'h00, 1, 0, 0, 1, 1};
    #12;
    check_model("reset");
    aclr = 1;
    for (int i = 0; i < 18; i++) begin
      drive(tv[i].w, tv[i].r, tv[i].d, 0);
      chk($sformatf("tv%0d.level", i), 32'(bus.level), tv[i].lvl);
      chk($sformatf("tv%0d.empty", i), 32'(bus.empty), 32'(tv[i].emp));
      chk($sformatf("tv%0d.hfull", i), 32'(bus.hfull), 32'(tv[i].hf));
      chk($sformatf("tv%0d.full", i), 32'(bus.full), 32'(tv[i].fl));
      chk($sformatf("tv%0d.ovf", i), 32'(bus.ovf), 32'(tv[i].ov));
      chk($sformatf("tv%0d.udf", i), 32'(bus.udf), 32'(tv[i].ud));
      if (!tv[i].emp) chk($sformatf("tv%0d.q", i), 32'(bus.q), 32'(tv[i].q));
    end
    drive(0, 0, 0, 1);
    for (int i = 0; i < 8; i++) drive(1, 0, 8'((i + 1) * 17), 0);
    drive(1, 1, 8'h99, 0);
    chk("full_rw.level", 32'(bus.level), 8);
    chk("full_rw.ovf", 32'(bus.ovf), 0);
    chk("full_rw.q", 32'(bus.q), 32'h22);
    for (int i = 0; i < 7; i++) drive(0, 1, 0, 0);
    chk("full_rw.last_q", 32'(bus.q), 32'h99);
    drive(0, 1, 0, 0);
    chk("full_rw.empty", 32'(bus.empty), 1);
    drive(1, 1, 8'h5A, 0);
    chk("empty_rw.udf", 32'(bus.udf), 1);
    chk("empty_rw.level", 32'(bus.level), 1);
    chk("empty_rw.q", 32'(bus.q), 32'h5A);
    chk("empty_rw.empty", 32'(bus.empty), 0);
    drive(0, 0, 0, 1);
    bus.afull_lvl = 6;
    bus.aempty_lvl = 1;
    for (int i = 1; i <= 6; i++) begin
      drive(1, 0, 8'(i), 0);
      chk($sformatf("thr%0d.aempty", i), 32'(bus.aempty), 32'(i <= 1));
      chk($sformatf("thr%0d.afull", i), 32'(bus.afull), 32'(i >= 6));
    end
    bus.afull_lvl = 7;
    #1;
    chk("thr.afull_drop", 32'(bus.afull), 0);
    bus.afull_lvl = 0;
    #1;
    chk("thr.afull_zero", 32'(bus.afull), 1);
    bus.afull_lvl = 8;
    drive(0, 0, 0, 1);
    for (int i = 0; i < 9; i++) drive(1, 0, 8'(i), 0);
    for (int i = 0; i < 3; i++) drive(0, 1, 0, 0);
    check_model("pre_sclr");
    drive(1, 0, 8'hC3, 1);
    chk("sclr.level", 32'(bus.level), 0);
    chk("sclr.empty", 32'(bus.empty), 1);
    chk("sclr.ovf", 32'(bus.ovf), 0);
    for (int k = 0; k < 30; k++) begin
      drive(1, 0, 8'(k + 1), 0);
      chk($sformatf("wrap%0d.q", k), 32'(bus.q), k + 1);
      drive(0, 1, 0, 0);
    end
    check_model("wrap_end");
    for (int i = 0; i < 3; i++) drive(1, 0, 8'(i), 0);
    #3;
    aclr = 0;
    #1;
    chk("aclr.level", 32'(bus.level), 0);
    chk("aclr.empty", 32'(bus.empty), 1);
    model_clear();
    #1;
    aclr = 1;
    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 0) wp = (i % 100 == 0) ? 80 : 25;
      bus.afull_lvl = 4'($urandom_range(0, 15));
      bus.aempty_lvl = 4'($urandom_range(0, 15));
      drive($urandom_range(0, 99) < wp, $urandom_range(0, 99) >= wp, 8'($urandom), $urandom_range(0, 39) == 0);
      check_model($sformatf("rnd%0d", i));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
